tc_pl_cap_gain_seq: RTL and testbench

Gain-change sequencer for one capture channel. On a gain request it latches the selected gain entry from the per-gain tables, then applies it in a fixed order: drive the relays, wait for them to settle, write the LMH attenuator over SPI, write DAC A then DAC B over SPI, wait the programmable post-delay, then pulse gain_cmpt. It sits between the PS-facing gain registers and the FDA/DAC SPI serializers. It owns their request/done handshakes.

---
 rtl/tc_pl_cap_gain_pkg.sv | 25 ++
 rtl/tc_pl_cap_gain_seq_if.sv | 23 ++
 rtl/tc_pl_cap_gain_tmr.sv | 20 ++
 rtl/tc_pl_cap_gain_seq.sv | 201 ++++++++++++++++++++
 tb/tb_tc_pl_cap_gain_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/tc_pl_cap_gain_pkg.sv
// Shared types and default widths for the capture-channel gain sequencer.
package tc_pl_cap_gain_pkg;

  localparam int GAIN_W         = 2;
  localparam int DAC_W          = 32;
  localparam int LMH_W          = 6;
  localparam int RELAY_W        = 4;
  localparam int SETTLE_CYC_DEF = 1250;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RELAY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LMH    = 3'd3,
    ST_DACA   = 3'd4,
    ST_DACB   = 3'd5,
    ST_DELAY  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tc_pl_cap_gain_seq_if.sv
// Request/done handshake bundle between the gain sequencer and the FDA/DAC SPI serializers.
interface tc_pl_cap_gain_seq_if #(
  parameter int LMH_W = 6,
  parameter int DAC_W = 32
);
  logic             lmh_req;
  logic [LMH_W-1:0] lmh_data;
  logic             lmh_done;
  logic             dac_req;
  logic             dac_sel;
  logic [DAC_W-1:0] dac_data;
  logic             dac_done;

  modport master (
    output lmh_req, lmh_data, dac_req, dac_sel, dac_data,
    input  lmh_done, dac_done
  );

  modport slave (
    input  lmh_req, lmh_data, dac_req, dac_sel, dac_data,
    output lmh_done, dac_done
  );
endinterface

// File: rtl/tc_pl_cap_gain_tmr.sv
// Loadable down-counter that stops at zero; shared by settle, post-delay and timeout.
module tc_pl_cap_gain_tmr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/tc_pl_cap_gain_seq.sv
// Gain-change sequencer: relay -> settle -> LMH SPI -> DAC A/B SPI -> post-delay -> gain_cmpt.
// Optional handshake timeout with sticky gain_err is built when CAP_GAIN_TIMEOUT_EN is defined.
module tc_pl_cap_gain_seq #(
  parameter int GAIN_W     = tc_pl_cap_gain_pkg::GAIN_W,
  parameter int DAC_W      = tc_pl_cap_gain_pkg::DAC_W,
  parameter int LMH_W      = tc_pl_cap_gain_pkg::LMH_W,
  parameter int RELAY_W    = tc_pl_cap_gain_pkg::RELAY_W,
  parameter int DEL_W      = 32,
  parameter int SETTLE_CYC = tc_pl_cap_gain_pkg::SETTLE_CYC_DEF,
  parameter int TO_CYC     = 65535
) (
  input  logic               clk125,
  input  logic               rst,
  input  logic [GAIN_W-1:0]  gain_value,
  input  logic               gain_en,
  input  logic [DEL_W-1:0]   cap_gain_del,
  input  logic [DAC_W-1:0]   cap_gain0_dacA, cap_gain1_dacA, cap_gain2_dacA, cap_gain3_dacA,
  input  logic [DAC_W-1:0]   cap_gain0_dacB, cap_gain1_dacB, cap_gain2_dacB, cap_gain3_dacB,
  input  logic [LMH_W-1:0]   cap_gain0_lmh, cap_gain1_lmh, cap_gain2_lmh, cap_gain3_lmh,
  input  logic [RELAY_W-1:0] cap_gain0_relay, cap_gain1_relay, cap_gain2_relay, cap_gain3_relay,
  output logic [RELAY_W-1:0] relay_out,
  tc_pl_cap_gain_seq_if.master spi,
  output logic               busy,
  output logic               gain_cmpt,
  output logic               gain_err
);
  import tc_pl_cap_gain_pkg::*;

  localparam int TMR_W = max_int(DEL_W, max_int($clog2(SETTLE_CYC + 1), $clog2(TO_CYC + 1)));

  state_e              state_q, state_d;
  logic                pend_vld_q, pend_vld_d;
  logic [GAIN_W-1:0]   pend_idx_q, pend_idx_d;
  logic                acc;
  logic [GAIN_W-1:0]   acc_idx;
  logic [RELAY_W-1:0]  relay_lat_q, relay_out_q, sel_relay;
  logic [LMH_W-1:0]    lmh_q, sel_lmh;
  logic [DAC_W-1:0]    daca_q, dacb_q, sel_daca, sel_dacb;
  logic [DEL_W-1:0]    del_q;
  logic                tmr_load, tmr_zero;
  logic [TMR_W-1:0]    tmr_val;
`ifdef CAP_GAIN_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TO_CYC - 1);
  logic                to_hit;
  logic                err_q;
`endif

  tc_pl_cap_gain_tmr #(.W(TMR_W)) u_tmr (
    .clk        (clk125),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    acc        = 1'b0;
    acc_idx    = gain_value;
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
`ifdef CAP_GAIN_TIMEOUT_EN
    to_hit     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (gain_en || pend_vld_q) begin
        acc     = 1'b1;
        acc_idx = gain_en ? gain_value : pend_idx_q;
        state_d = ST_RELAY;
      end
      ST_RELAY: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(SETTLE_CYC - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: if (tmr_zero) begin
        state_d = ST_LMH;
`ifdef CAP_GAIN_TIMEOUT_EN
        tmr_load = 1'b1;
        tmr_val  = TO_LOAD;
`endif
      end
      ST_LMH, ST_DACA, ST_DACB: begin
        if ((state_q == ST_LMH) ? spi.lmh_done : spi.dac_done) begin
          if (state_q == ST_DACB) begin
            if (del_q == '0) state_d = ST_DONE;
            else begin
              state_d  = ST_DELAY;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(del_q - DEL_W'(1));
            end
          end else begin
            state_d = (state_q == ST_LMH) ? ST_DACA : ST_DACB;
`ifdef CAP_GAIN_TIMEOUT_EN
            tmr_load = 1'b1;
            tmr_val  = TO_LOAD;
`endif
          end
        end
`ifdef CAP_GAIN_TIMEOUT_EN
        else if (tmr_zero) begin
          to_hit  = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DELAY: if (tmr_zero) state_d = ST_DONE;
      ST_DONE: begin
        if (pend_vld_q) begin
          acc     = 1'b1;
          acc_idx = pend_idx_q;
          state_d = ST_RELAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept consumes the slot; a request seen outside IDLE (including DONE) refills it.
    if (acc) pend_vld_d = 1'b0;
    if (gain_en && state_q != ST_IDLE) begin
      pend_vld_d = 1'b1;
      pend_idx_d = gain_value;
    end
  end

  always_comb begin
    sel_relay = cap_gain0_relay;
    sel_lmh   = cap_gain0_lmh;
    sel_daca  = cap_gain0_dacA;
    sel_dacb  = cap_gain0_dacB;
    case (acc_idx)
      GAIN_W'(1): begin
        sel_relay = cap_gain1_relay; sel_lmh = cap_gain1_lmh;
        sel_daca  = cap_gain1_dacA;  sel_dacb = cap_gain1_dacB;
      end
      GAIN_W'(2): begin
        sel_relay = cap_gain2_relay; sel_lmh = cap_gain2_lmh;
        sel_daca  = cap_gain2_dacA;  sel_dacb = cap_gain2_dacB;
      end
      GAIN_W'(3): begin
        sel_relay = cap_gain3_relay; sel_lmh = cap_gain3_lmh;
        sel_daca  = cap_gain3_dacA;  sel_dacb = cap_gain3_dacB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk125) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= '0;
      relay_lat_q <= '0;
      relay_out_q <= '0;
      lmh_q       <= '0;
      daca_q      <= '0;
      dacb_q      <= '0;
      del_q       <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      if (acc) begin
        relay_lat_q <= sel_relay;
        lmh_q       <= sel_lmh;
        daca_q      <= sel_daca;
        dacb_q      <= sel_dacb;
        del_q       <= cap_gain_del;
      end
      if (state_q == ST_RELAY) relay_out_q <= relay_lat_q;
    end
  end

`ifdef CAP_GAIN_TIMEOUT_EN
  always_ff @(posedge clk125) begin
    if (rst)         err_q <= 1'b0;
    else if (acc)    err_q <= 1'b0;
    else if (to_hit) err_q <= 1'b1;
  end
  assign gain_err = err_q;
`else
  assign gain_err = 1'b0;
`endif

  // Requests and payloads decode straight from the state register, so they only move on transitions.
  assign spi.lmh_req  = (state_q == ST_LMH);
  assign spi.lmh_data = (state_q == ST_LMH) ? lmh_q : '0;
  assign spi.dac_req  = (state_q == ST_DACA) || (state_q == ST_DACB);
  assign spi.dac_sel  = (state_q == ST_DACB);
  assign spi.dac_data = (state_q == ST_DACA) ? daca_q :
                        (state_q == ST_DACB) ? dacb_q : '0;
  assign relay_out    = relay_out_q;
  assign busy         = (state_q != ST_IDLE);
  assign gain_cmpt    = (state_q == ST_DONE);
endmodule

// File: tb/tb_tc_pl_cap_gain_seq.sv
// Directed bench for tc_pl_cap_gain_seq; the timeout scenario runs only when CAP_GAIN_TIMEOUT_EN is defined.
module tb_tc_pl_cap_gain_seq;
  localparam int GW = 2, DW = 32, LW = 6, RW = 4, DLW = 32;
  localparam int SETTLE = 1250;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst, gain_en;
  logic [GW-1:0]  gain_value;
  logic [DLW-1:0] del;
  logic [DW-1:0]  daca [4];
  logic [DW-1:0]  dacb [4];
  logic [LW-1:0]  lmh  [4];
  logic [RW-1:0]  rly  [4];
  logic [RW-1:0]  relay_out;
  logic           busy, gain_cmpt, gain_err;

  tc_pl_cap_gain_seq_if #(.LMH_W(LW), .DAC_W(DW)) spi_if ();

  tc_pl_cap_gain_seq #(
    .GAIN_W(GW), .DAC_W(DW), .LMH_W(LW), .RELAY_W(RW), .DEL_W(DLW),
    .SETTLE_CYC(SETTLE), .TO_CYC(TO)
  ) dut (
    .clk125(clk), .rst(rst), .gain_value(gain_value), .gain_en(gain_en), .cap_gain_del(del),
    .cap_gain0_dacA(daca[0]), .cap_gain1_dacA(daca[1]), .cap_gain2_dacA(daca[2]), .cap_gain3_dacA(daca[3]),
    .cap_gain0_dacB(dacb[0]), .cap_gain1_dacB(dacb[1]), .cap_gain2_dacB(dacb[2]), .cap_gain3_dacB(dacb[3]),
    .cap_gain0_lmh(lmh[0]), .cap_gain1_lmh(lmh[1]), .cap_gain2_lmh(lmh[2]), .cap_gain3_lmh(lmh[3]),
    .cap_gain0_relay(rly[0]), .cap_gain1_relay(rly[1]), .cap_gain2_relay(rly[2]), .cap_gain3_relay(rly[3]),
    .relay_out(relay_out), .spi(spi_if), .busy(busy), .gain_cmpt(gain_cmpt), .gain_err(gain_err)
  );

  always #4 clk = ~clk;

  int checks = 0, errors = 0;
  int t = 0, t0 = 0, cmpt_cnt = 0, c0 = 0;
  bit overlap = 1'b0;
  bit ok;

  // t advances once per rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    t++;
    if (gain_cmpt) cmpt_cnt++;
    if (spi_if.lmh_req && spi_if.dac_req) overlap = 1'b1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 = lmh_req, 1 = dac_req, 2 = gain_cmpt
  task automatic wait_sig(input int which, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 && spi_if.lmh_req) || (which == 1 && spi_if.dac_req) ||
          (which == 2 && gain_cmpt)) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic start(input logic [GW-1:0] idx);
    gain_value = idx;
    gain_en    = 1'b1;
    t0         = t;
    step();
    gain_en    = 1'b0;
  endtask

  // Serializer model: req held lat cycles, done pulsed in the last of them.
  task automatic xfer(input string tag, input bit is_dac, input bit sel,
                      input logic [DW-1:0] exp, input int lat);
    bit found, stable;
    logic [63:0] d;
    wait_sig(is_dac ? 1 : 0, 3000, found);
    check({tag, " req"}, 64'(found), 64'd1);
    d = is_dac ? 64'(spi_if.dac_data) : 64'(spi_if.lmh_data);
    check({tag, " data"}, d, 64'(exp));
    if (is_dac) check({tag, " sel"}, 64'(spi_if.dac_sel), 64'(sel));
    stable = 1'b1;
    for (int i = 1; i < lat; i++) begin
      step();
      if (is_dac) begin
        if (!(spi_if.dac_req && spi_if.dac_data == exp && spi_if.dac_sel == sel)) stable = 1'b0;
      end else if (!(spi_if.lmh_req && DW'(spi_if.lmh_data) == exp)) stable = 1'b0;
    end
    if (is_dac) spi_if.dac_done = 1'b1;
    else        spi_if.lmh_done = 1'b1;
    step();
    spi_if.dac_done = 1'b0;
    spi_if.lmh_done = 1'b0;
    check({tag, " held"}, 64'(stable), 64'd1);
    if (is_dac && !sel) check({tag, " moved to B"}, 64'(spi_if.dac_sel), 64'd1);
    else check({tag, " req drop"}, 64'(is_dac ? spi_if.dac_req : spi_if.lmh_req), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; gain_en = 1'b0; gain_value = '0; del = '0;
    spi_if.lmh_done = 1'b0; spi_if.dac_done = 1'b0;
    rly[0] = 4'h1; lmh[0] = 6'd3;  daca[0] = 32'h1000_0000; dacb[0] = 32'h1000_0001;
    rly[1] = 4'h5; lmh[1] = 6'd9;  daca[1] = 32'h1111_000A; dacb[1] = 32'h1111_000B;
    rly[2] = 4'hA; lmh[2] = 6'd17; daca[2] = 32'h0000_1234; dacb[2] = 32'h0000_5678;
    rly[3] = 4'hC; lmh[3] = 6'd33; daca[3] = 32'h3333_AAAA; dacb[3] = 32'h3333_BBBB;
    repeat (3) step();
    check("rst relay_out", 64'(relay_out), 64'h0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst reqs", {62'd0, spi_if.lmh_req, spi_if.dac_req}, 64'd0);
    check("rst cmpt/err", {62'd0, gain_cmpt, gain_err}, 64'd0);
    rst = 1'b0;
    step();

    // 1: gain 2, delay 10, 20-cycle SPI transfers
    del = 32'd10;
    start(2'd2);
    check("t1 busy@1", 64'(busy), 64'd1);
    check("t1 relay@1", 64'(relay_out), 64'h0);
    step();
    check("t1 relay@2", 64'(relay_out), 64'hA);
    wait_sig(0, 2000, ok);
    check("t1 lmh_req cycle", 64'(t - t0), 64'd1252);
    xfer("t1 lmh", 1'b0, 1'b0, 32'd17, 20);
    xfer("t1 dacA", 1'b1, 1'b0, 32'h1234, 20);
    xfer("t1 dacB", 1'b1, 1'b1, 32'h5678, 20);
    wait_sig(2, 100, ok);
    // gain_cmpt occupies cycle 2+1250+60+10 = 1322, i.e. the 1323rd cycle counting the gain_en cycle
    check("t1 cmpt cycle", 64'(t - t0), 64'd1322);
    step();
    check("t1 cmpt width", 64'(gain_cmpt), 64'd0);
    check("t1 idle", 64'(busy), 64'd0);
    check("t1 relay held", 64'(relay_out), 64'hA);

    // 2: zero delay goes from DAC B done straight to DONE
    del = 32'd0; c0 = cmpt_cnt;
    start(2'd0);
    xfer("t2 lmh", 1'b0, 1'b0, 32'd3, 4);
    xfer("t2 dacA", 1'b1, 1'b0, 32'h1000_0000, 3);
    xfer("t2 dacB", 1'b1, 1'b1, 32'h1000_0001, 5);
    check("t2 cmpt now", 64'(gain_cmpt), 64'd1);
    repeat (20) step();
    check("t2 one cmpt", 64'(cmpt_cnt - c0), 64'd1);
    check("t2 relay", 64'(relay_out), 64'h1);

    // 3: two requests during SETTLE, only the last one runs afterwards
    del = 32'd5; c0 = cmpt_cnt;
    start(2'd0);
    repeat (9) step();
    gain_value = 2'd1; gain_en = 1'b1; step(); gain_en = 1'b0;
    repeat (9) step();
    gain_value = 2'd3; gain_en = 1'b1; step(); gain_en = 1'b0;
    xfer("t3a lmh", 1'b0, 1'b0, 32'd3, 6);
    xfer("t3a dacA", 1'b1, 1'b0, 32'h1000_0000, 6);
    xfer("t3a dacB", 1'b1, 1'b1, 32'h1000_0001, 6);
    wait_sig(2, 100, ok);
    check("t3 first cmpt", 64'(ok), 64'd1);
    step();
    check("t3 restart busy", 64'(busy), 64'd1);
    step();
    check("t3 relay gain3", 64'(relay_out), 64'hC);
    xfer("t3b lmh", 1'b0, 1'b0, 32'd33, 7);
    xfer("t3b dacA", 1'b1, 1'b0, 32'h3333_AAAA, 7);
    xfer("t3b dacB", 1'b1, 1'b1, 32'h3333_BBBB, 7);
    repeat (20) step();
    check("t3 two cmpt", 64'(cmpt_cnt - c0), 64'd2);
    check("t3 idle", 64'(busy), 64'd0);

    // 4: reset while DAC A is requesting
    del = 32'd2;
    start(2'd2);
    xfer("t4 lmh", 1'b0, 1'b0, 32'd17, 5);
    check("t4 dac_req up", 64'(spi_if.dac_req), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4 dac_req drop", 64'(spi_if.dac_req), 64'd0);
    check("t4 relay cleared", 64'(relay_out), 64'h0);
    check("t4 busy", 64'(busy), 64'd0);
    spi_if.dac_done = 1'b1; step(); spi_if.dac_done = 1'b0;
    step();
    check("t4 stray done", {61'd0, busy, spi_if.dac_req, spi_if.lmh_req}, 64'd0);

    // 5: table edits after accept do not reach the DAC writes
    del = 32'd3; c0 = cmpt_cnt;
    start(2'd1);
    wait_sig(0, 2000, ok);
    daca[1] = 32'hDEAD_0001; dacb[1] = 32'hDEAD_0002; lmh[1] = 6'd60;
    xfer("t5 lmh", 1'b0, 1'b0, 32'd9, 3);
    xfer("t5 dacA", 1'b1, 1'b0, 32'h1111_000A, 3);
    xfer("t5 dacB", 1'b1, 1'b1, 32'h1111_000B, 3);
    wait_sig(2, 100, ok);
    step();
    check("t5 cmpt", 64'(cmpt_cnt - c0), 64'd1);
    check("t5 relay", 64'(relay_out), 64'h5);

`ifdef CAP_GAIN_TIMEOUT_EN
    // 6: LMH never answers; request drops after TO cycles and the error sticks
    c0 = cmpt_cnt;
    start(2'd0);
    wait_sig(0, 2000, ok);
    t0 = t;
    while (spi_if.lmh_req && (t - t0) < 200) step();
    check("t6 req duration", 64'(t - t0), 64'd100);
    check("t6 cmpt", 64'(gain_cmpt), 64'd1);
    check("t6 err", 64'(gain_err), 64'd1);
    wait_sig(1, 50, ok);
    check("t6 no dac", 64'(ok), 64'd0);
    check("t6 err sticky", 64'(gain_err), 64'd1);
    check("t6 one cmpt", 64'(cmpt_cnt - c0), 64'd1);
`else
    check("gain_err tied", 64'(gain_err), 64'd0);
`endif

    check("req overlap", 64'(overlap), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
